// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - segment pattern constants and types for the seven-segment decoder
// Purpose: shared segment-vector type, lit patterns for 0-9 and A-F, blank, polarity helper.
// Ports: none (package).
package seven_segment_pkg;

    // Segment vector, bit order a..g with a in the MSB.
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Common-anode displays want every segment inverted, blank included.
    function automatic seg_t apply_polarity(input seg_t pattern, input bit active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_segment_decoder_if.sv
// rtl/seven_segment_decoder_if.sv - code-in / segments-out bundle for the seven-segment decoder
// Purpose: groups the 4 code bits and the 7 segment outputs.
// Signals: x0 (code MSB) .. x3 (code LSB); a..g segment enables.
// Modports: master drives the code and reads segments; slave is the decoder side.
interface seven_segment_decoder_if;

    logic x0;
    logic x1;
    logic x2;
    logic x3;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;

    modport master (
        output x0, x1, x2, x3,
        input  a, b, c, d, e, f, g
    );

    modport slave (
        input  x0, x1, x2, x3,
        output a, b, c, d, e, f, g
    );

endinterface

// File: rtl/seven_segment_lut.sv
// rtl/seven_segment_lut.sv - combinational code-to-segment lookup
// Purpose: maps a 4-bit code to an unregistered lit pattern (a..g, active-high).
// Ports: code (4-bit, in), hex_en (in, 1 = show A-F for 10-15), pattern (7-bit, out).
module seven_segment_lut
    import seven_segment_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output seg_t       pattern
);

    // Case items compare exactly, so a code carrying X/Z matches nothing
    // and falls to the default blank rather than propagating X.
    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            4'd10:   pattern = hex_en ? SEG_A : SEG_BLANK;
            4'd11:   pattern = hex_en ? SEG_B : SEG_BLANK;
            4'd12:   pattern = hex_en ? SEG_C : SEG_BLANK;
            4'd13:   pattern = hex_en ? SEG_D : SEG_BLANK;
            4'd14:   pattern = hex_en ? SEG_E : SEG_BLANK;
            4'd15:   pattern = hex_en ? SEG_F : SEG_BLANK;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - registered BCD/hex to seven-segment decoder
// Purpose: decodes {x0,x1,x2,x3} into registered segment enables, one cycle latency.
// Ports: clk (rising edge), rst (sync, active-high), bus (slave: x0..x3 in, a..g out).
// Parameters: ACTIVE_LOW (1 = invert all segments), HEX_EN (1 = show A-F for 10-15).
module seven_segment_decoder
    import seven_segment_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HEX_EN     = 1'b0
)
(
    input  logic                        clk,
    input  logic                        rst,
    seven_segment_decoder_if.slave      bus
);

    localparam seg_t SEG_UNLIT = apply_polarity(SEG_BLANK, ACTIVE_LOW);

    logic [3:0] code;
    seg_t       pattern;
    seg_t       seg_d;
    seg_t       seg_q;

    assign code = {bus.x0, bus.x1, bus.x2, bus.x3};

    seven_segment_lut u_lut (
        .code    (code),
        .hex_en  (HEX_EN),
        .pattern (pattern)
    );

    always_comb begin
        seg_d = apply_polarity(pattern, ACTIVE_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_UNLIT;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign bus.a = seg_q[6];
    assign bus.b = seg_q[5];
    assign bus.c = seg_q[4];
    assign bus.d = seg_q[3];
    assign bus.e = seg_q[2];
    assign bus.f = seg_q[1];
    assign bus.g = seg_q[0];

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - self-checking bench for seven_segment_decoder
module tb_seven_segment_decoder;

    typedef struct {
        string      tag;
        logic [6:0] e_dec;
        logic [6:0] e_hex;
        logic [6:0] e_al;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code_drv = 4'd8;
    int         n_assert = 0;
    int         n_fail = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    seven_segment_decoder_if if_dec ();
    seven_segment_decoder_if if_hex ();
    seven_segment_decoder_if if_al ();

    assign {if_dec.x0, if_dec.x1, if_dec.x2, if_dec.x3} = code_drv;
    assign {if_hex.x0, if_hex.x1, if_hex.x2, if_hex.x3} = code_drv;
    assign {if_al.x0,  if_al.x1,  if_al.x2,  if_al.x3}  = code_drv;

    seven_segment_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_dec (.clk(clk), .rst(rst), .bus(if_dec.slave));
    seven_segment_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_hex (.clk(clk), .rst(rst), .bus(if_hex.slave));
    seven_segment_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_al  (.clk(clk), .rst(rst), .bus(if_al.slave));

    function automatic logic [6:0] model(input logic [3:0] c, input bit hex, input bit al, input logic r);
        logic [6:0] p;
        if (r === 1'b1) return al ? 7'b1111111 : 7'b0000000;
        if ($isunknown(c)) p = 7'b0000000;
        else begin
            case (c)
                4'd0:  p = 7'b1111110;
                4'd1:  p = 7'b0110000;
                4'd2:  p = 7'b1101101;
                4'd3:  p = 7'b1111001;
                4'd4:  p = 7'b0110011;
                4'd5:  p = 7'b1011011;
                4'd6:  p = 7'b1011111;
                4'd7:  p = 7'b1110000;
                4'd8:  p = 7'b1111111;
                4'd9:  p = 7'b1111011;
                4'd10: p = hex ? 7'b1110111 : 7'b0000000;
                4'd11: p = hex ? 7'b0011111 : 7'b0000000;
                4'd12: p = hex ? 7'b1001110 : 7'b0000000;
                4'd13: p = hex ? 7'b0111101 : 7'b0000000;
                4'd14: p = hex ? 7'b1001111 : 7'b0000000;
                default: p = hex ? 7'b1000111 : 7'b0000000;
            endcase
        end
        return al ? ~p : p;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input exp_t e, input string sfx);
        check({e.tag, "_dec", sfx}, {if_dec.a, if_dec.b, if_dec.c, if_dec.d, if_dec.e, if_dec.f, if_dec.g}, e.e_dec);
        check({e.tag, "_hex", sfx}, {if_hex.a, if_hex.b, if_hex.c, if_hex.d, if_hex.e, if_hex.f, if_hex.g}, e.e_hex);
        check({e.tag, "_al", sfx},  {if_al.a,  if_al.b,  if_al.c,  if_al.d,  if_al.e,  if_al.f,  if_al.g},  e.e_al);
    endtask

    // Drive one code for one edge, compare one edge later, then disturb the
    // inputs mid-cycle and confirm the registered outputs do not move.
    task automatic step(input logic [3:0] c, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        code_drv = c;
        rst      = r;
        sb.push_back('{tag, model(code_drv, 1'b0, 1'b0, rst), model(code_drv, 1'b1, 1'b0, rst), model(code_drv, 1'b0, 1'b1, rst)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_all(e, "");
        code_drv = ~c;
        #2;
        check_all(e, "_hold");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        step(4'd8, 1'b1, "rst0");
        step(4'd8, 1'b1, "rst1");
        step(4'd8, 1'b0, "rel8");
        for (int i = 0; i < 10; i++) step(4'(i), 1'b0, $sformatf("dec%0d", i));
        for (int i = 10; i < 16; i++) step(4'(i), 1'b0, $sformatf("hi%0d", i));
        step(4'bxxxx, 1'b0, "xcode");
        step(4'd1, 1'b0, "pol1");
        step(4'd0, 1'b0, "pol0");
        step(4'd3, 1'b0, "mid3");
        step(4'd5, 1'b0, "mid5");
        step(4'd9, 1'b1, "midrst9");
        step(4'd9, 1'b0, "midrel9");
        step(4'd2, 1'b0, "dec2b");
        step(4'd7, 1'b0, "dec7b");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
